// File: rtl/dsec_rx_control.sv
// DSEC receive-side control: captures link words into a small FIFO, feeds the
// decompression path through a registered valid/ready stage, and sequences flush/dump/error.
module dsec_rx_control #(
    parameter int DATA_W = 64,
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              key_config,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_rcvd,
    input  logic              flush,
    input  logic              decomp_rdy,
    output logic [DATA_W-1:0] data_to_decomp,
    output logic              valid_to_decomp,
    output logic              dump_decomp,
    output logic              stall,
    output logic              error,
    output logic [7:0]        error_code,
    input  logic              err_clr,
    output logic [ADDR_W:0]   count
);

    typedef enum logic [1:0] {
        ST_RUN,
        ST_DRAIN,
        ST_DUMP,
        ST_HALT
    } state_e;

    localparam logic [ADDR_W:0] FULL_CNT   = (ADDR_W+1)'(DEPTH);
    localparam logic [7:0]      ERR_OVF    = 8'h01;
    localparam logic [7:0]      ERR_KEY    = 8'h02;
    localparam logic [7:0]      ERR_EOS_IN = 8'h03;
    localparam logic [7:0]      ERR_EOS_FL = 8'h04;

    state_e              state_q, state_d;
    logic [DATA_W-1:0]   mem_q [DEPTH];
    logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]     count_q, count_d;
    logic                rcvd_q, rcvd_d;
    logic                valid_q, valid_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic                error_q, error_d;
    logic [7:0]          code_q, code_d;

    logic                in_eos;
    logic                fifo_full;
    logic                fifo_empty;
    logic                out_fire;
    logic                load;
    logic                wr_en;
    logic                err_det;
    logic [7:0]          err_val;

    always_comb begin
        in_eos     = (state_q == ST_DRAIN) || (state_q == ST_DUMP);
        fifo_full  = (count_q == FULL_CNT);
        fifo_empty = (count_q == '0);
        stall      = key_config | error_q;
        out_fire   = valid_q & decomp_rdy;
        // Output register may refill in the same edge its word is accepted.
        load       = (~valid_q | out_fire) & ~fifo_empty & ~stall;
        wr_en      = (state_q == ST_RUN) & in_valid & ~key_config & ~fifo_full;
    end

    always_comb begin
        err_det = 1'b1;
        err_val = '0;
        if (in_valid && key_config) begin
            err_val = ERR_KEY;
        end else if (in_valid && in_eos) begin
            err_val = ERR_EOS_IN;
        end else if (in_valid && fifo_full) begin
            err_val = ERR_OVF;
        end else if (flush && in_eos) begin
            err_val = ERR_EOS_FL;
        end else begin
            err_det = 1'b0;
        end
    end

    always_comb begin
        state_d = state_q;
        if (err_det) begin
            state_d = ST_HALT;
        end else begin
            case (state_q)
                ST_RUN:   if (flush) state_d = ST_DRAIN;
                ST_DRAIN: if (!key_config && fifo_empty && !valid_q) state_d = ST_DUMP;
                ST_DUMP:  if (decomp_rdy && !key_config) state_d = ST_RUN;
                ST_HALT:  if (err_clr) state_d = ST_RUN;
                default:  state_d = ST_RUN;
            endcase
        end
    end

    always_comb begin
        error_d = err_det | (error_q & ~err_clr);
        code_d  = code_q;
        // Only the first error since the last clear is recorded.
        if (err_det && (!error_q || err_clr)) begin
            code_d = err_val;
        end else if (err_clr && !err_det) begin
            code_d = '0;
        end
    end

    always_comb begin
        wr_ptr_d = wr_en ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = load  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d  = count_q;
        case ({wr_en, load})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        valid_d = valid_q;
        data_d  = data_q;
        if (load) begin
            valid_d = 1'b1;
            data_d  = mem_q[rd_ptr_q];
        end else if (out_fire) begin
            valid_d = 1'b0;
        end
        rcvd_d = wr_en;
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= in_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_RUN;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            rcvd_q   <= 1'b0;
            valid_q  <= 1'b0;
            data_q   <= '0;
            error_q  <= 1'b0;
            code_q   <= '0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            rcvd_q   <= rcvd_d;
            valid_q  <= valid_d;
            data_q   <= data_d;
            error_q  <= error_d;
            code_q   <= code_d;
        end
    end

    assign in_rcvd         = rcvd_q;
    assign valid_to_decomp = valid_q;
    assign data_to_decomp  = data_q;
    assign dump_decomp     = (state_q == ST_DUMP);
    assign error           = error_q;
    assign error_code      = code_q;
    assign count           = count_q;

endmodule

// File: tb/tb_dsec_rx_control.sv
// Bench for dsec_rx_control: directed vector table, a reset-mid-stream sequence,
// and random traffic compared against a queue-based reference model.
module tb_dsec_rx_control;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        key_config;
    logic        in_valid;
    logic [63:0] in_data;
    logic        in_rcvd;
    logic        flush;
    logic        decomp_rdy;
    logic [63:0] data_to_decomp;
    logic        valid_to_decomp;
    logic        dump_decomp;
    logic        stall;
    logic        error;
    logic [7:0]  error_code;
    logic        err_clr;
    logic [2:0]  count;

    int total = 0;
    int bad   = 0;

    dsec_rx_control #(.DATA_W(64), .DEPTH(DEPTH), .ADDR_W(2)) dut (
        .clk             (clk),
        .rst             (rst),
        .key_config      (key_config),
        .in_valid        (in_valid),
        .in_data         (in_data),
        .in_rcvd         (in_rcvd),
        .flush           (flush),
        .decomp_rdy      (decomp_rdy),
        .data_to_decomp  (data_to_decomp),
        .valid_to_decomp (valid_to_decomp),
        .dump_decomp     (dump_decomp),
        .stall           (stall),
        .error           (error),
        .error_code      (error_code),
        .err_clr         (err_clr),
        .count           (count)
    );

    always #5 clk = ~clk;

    // Reference model: FIFO as a queue, output register, mode flags
    logic [63:0] mq[$];
    bit          m_ov;
    logic [63:0] m_od;
    bit          m_rcvd;
    bit          m_err;
    logic [7:0]  m_code;
    bit          m_drain;
    bit          m_dump;

    task automatic model_reset();
        mq.delete();
        m_ov = 0; m_od = '0; m_rcvd = 0; m_err = 0; m_code = '0;
        m_drain = 0; m_dump = 0;
    endtask

    task automatic model_step(input bit iv, input logic [63:0] d, input bit fl,
                              input bit rdy, input bit kc, input bit clr);
        int n;
        bit eos, e, ov0, take, give, put;
        logic [7:0] c;
        n   = mq.size();
        ov0 = m_ov;
        eos = m_drain || m_dump;
        e   = 1;
        c   = 8'h00;
        if (iv && kc)              c = 8'h02;
        else if (iv && eos)        c = 8'h03;
        else if (iv && n == DEPTH) c = 8'h01;
        else if (fl && eos)        c = 8'h04;
        else                       e = 0;

        take = m_ov && rdy;
        give = (!m_ov || take) && n > 0 && !kc && !m_err;
        put  = iv && !kc && !eos && !m_err && n < DEPTH;
        if (give) begin
            m_od = mq.pop_front();
            m_ov = 1;
        end else if (take) begin
            m_ov = 0;
        end
        if (put) mq.push_back(d);
        m_rcvd = put;

        if (e) begin
            m_drain = 0; m_dump = 0;
        end else if (m_err) begin
            // halted: flush requests are dropped
        end else if (m_drain) begin
            if (!kc && n == 0 && !ov0) begin m_drain = 0; m_dump = 1; end
        end else if (m_dump) begin
            if (rdy && !kc) m_dump = 0;
        end else if (fl) begin
            m_drain = 1;
        end

        if (e && (!m_err || clr)) m_code = c;
        else if (clr && !e)       m_code = 8'h00;
        m_err = e || (m_err && !clr);
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Called at a negedge; applies inputs, steps the model at the posedge, returns at the next negedge.
    task automatic drive_cycle(input bit iv, input logic [63:0] d, input bit fl,
                               input bit rdy, input bit kc, input bit clr);
        in_valid = iv; in_data = d; flush = fl; decomp_rdy = rdy; key_config = kc; err_clr = clr;
        @(posedge clk);
        model_step(iv, d, fl, rdy, kc, clr);
        @(negedge clk);
    endtask

    task automatic cmp_model();
        chk("mdl_rcvd",  64'(in_rcvd),         64'(m_rcvd));
        chk("mdl_valid", 64'(valid_to_decomp), 64'(m_ov));
        chk("mdl_data",  data_to_decomp,       m_od);
        chk("mdl_dump",  64'(dump_decomp),     64'(m_dump));
        chk("mdl_error", 64'(error),           64'(m_err));
        chk("mdl_code",  64'(error_code),      64'(m_code));
        chk("mdl_count", 64'(count),           64'(mq.size()));
        chk("mdl_stall", 64'(stall),           64'(key_config | m_err));
    endtask

    typedef struct {
        bit          iv;
        logic [63:0] d;
        bit          fl, rdy, kc, clr;
        bit          e_rcvd, e_valid;
        logic [63:0] e_data;
        bit          e_dump, e_err;
        logic [7:0]  e_code;
        logic [2:0]  e_count;
        bit          e_stall;
    } vec_t;

    function automatic vec_t mk(bit iv, logic [63:0] d, bit fl, bit rdy, bit kc, bit clr,
                                bit rc, bit vl, logic [63:0] ed, bit dp, bit er,
                                logic [7:0] cd, int cnt, bit st);
        vec_t v;
        v.iv = iv; v.d = d; v.fl = fl; v.rdy = rdy; v.kc = kc; v.clr = clr;
        v.e_rcvd = rc; v.e_valid = vl; v.e_data = ed; v.e_dump = dp; v.e_err = er;
        v.e_code = cd; v.e_count = 3'(cnt); v.e_stall = st;
        return v;
    endfunction

    vec_t tab[$];

    initial begin
        logic [63:0] w0;
        w0 = 64'hDEADBEEF_01234567;

        // single word
        tab.push_back(mk(1, w0, 0, 1, 0, 0,  1, 0, 0,  0, 0, 8'h00, 1, 0));
        tab.push_back(mk(0, 0,  0, 1, 0, 0,  0, 1, w0, 0, 0, 8'h00, 0, 0));
        tab.push_back(mk(0, 0,  0, 1, 0, 0,  0, 0, 0,  0, 0, 8'h00, 0, 0));
        // backpressure fill, overflow, recovery
        tab.push_back(mk(1, 1, 0, 0, 0, 0,  1, 0, 0, 0, 0, 8'h00, 1, 0));
        tab.push_back(mk(1, 2, 0, 0, 0, 0,  1, 1, 1, 0, 0, 8'h00, 1, 0));
        tab.push_back(mk(1, 3, 0, 0, 0, 0,  1, 1, 1, 0, 0, 8'h00, 2, 0));
        tab.push_back(mk(1, 4, 0, 0, 0, 0,  1, 1, 1, 0, 0, 8'h00, 3, 0));
        tab.push_back(mk(1, 5, 0, 0, 0, 0,  1, 1, 1, 0, 0, 8'h00, 4, 0));
        tab.push_back(mk(1, 6, 0, 0, 0, 0,  0, 1, 1, 0, 1, 8'h01, 4, 1));
        tab.push_back(mk(0, 0, 0, 1, 0, 1,  0, 0, 0, 0, 0, 8'h00, 4, 0));
        tab.push_back(mk(0, 0, 0, 1, 0, 0,  0, 1, 2, 0, 0, 8'h00, 3, 0));
        tab.push_back(mk(0, 0, 0, 1, 0, 0,  0, 1, 3, 0, 0, 8'h00, 2, 0));
        tab.push_back(mk(0, 0, 0, 1, 0, 0,  0, 1, 4, 0, 0, 8'h00, 1, 0));
        tab.push_back(mk(0, 0, 0, 1, 0, 0,  0, 1, 5, 0, 0, 8'h00, 0, 0));
        tab.push_back(mk(0, 0, 0, 1, 0, 0,  0, 0, 0, 0, 0, 8'h00, 0, 0));
        // flush, drain, dump handshake, resume
        tab.push_back(mk(1, 64'hA, 0, 1, 0, 0,  1, 0, 0,     0, 0, 8'h00, 1, 0));
        tab.push_back(mk(1, 64'hB, 0, 1, 0, 0,  1, 1, 64'hA, 0, 0, 8'h00, 1, 0));
        tab.push_back(mk(1, 64'hC, 0, 1, 0, 0,  1, 1, 64'hB, 0, 0, 8'h00, 1, 0));
        tab.push_back(mk(0, 0,     1, 1, 0, 0,  0, 1, 64'hC, 0, 0, 8'h00, 0, 0));
        tab.push_back(mk(0, 0,     0, 1, 0, 0,  0, 0, 0,     0, 0, 8'h00, 0, 0));
        tab.push_back(mk(0, 0,     0, 0, 0, 0,  0, 0, 0,     1, 0, 8'h00, 0, 0));
        tab.push_back(mk(0, 0,     0, 0, 0, 0,  0, 0, 0,     1, 0, 8'h00, 0, 0));
        tab.push_back(mk(0, 0,     0, 1, 0, 0,  0, 0, 0,     0, 0, 8'h00, 0, 0));
        tab.push_back(mk(1, 64'hD, 0, 1, 0, 0,  1, 0, 0,     0, 0, 8'h00, 1, 0));
        tab.push_back(mk(0, 0,     0, 1, 0, 0,  0, 1, 64'hD, 0, 0, 8'h00, 0, 0));
        tab.push_back(mk(0, 0,     0, 1, 0, 0,  0, 0, 0,     0, 0, 8'h00, 0, 0));
        // key_config: stall with held word, error 02, later overflow keeps 02
        tab.push_back(mk(1, 64'h10, 0, 0, 0, 0,  1, 0, 0,      0, 0, 8'h00, 1, 0));
        tab.push_back(mk(1, 64'h11, 0, 0, 0, 0,  1, 1, 64'h10, 0, 0, 8'h00, 1, 0));
        tab.push_back(mk(1, 64'h12, 0, 0, 0, 0,  1, 1, 64'h10, 0, 0, 8'h00, 2, 0));
        tab.push_back(mk(1, 64'h13, 0, 0, 0, 0,  1, 1, 64'h10, 0, 0, 8'h00, 3, 0));
        tab.push_back(mk(1, 64'h14, 0, 0, 0, 0,  1, 1, 64'h10, 0, 0, 8'h00, 4, 0));
        tab.push_back(mk(0, 0,      0, 0, 1, 0,  0, 1, 64'h10, 0, 0, 8'h00, 4, 1));
        tab.push_back(mk(1, 64'h15, 0, 0, 1, 0,  0, 1, 64'h10, 0, 1, 8'h02, 4, 1));
        tab.push_back(mk(1, 64'h16, 0, 0, 0, 0,  0, 1, 64'h10, 0, 1, 8'h02, 4, 1));
        tab.push_back(mk(0, 0,      0, 1, 0, 1,  0, 0, 0,      0, 0, 8'h00, 4, 0));
        tab.push_back(mk(0, 0,      0, 1, 0, 0,  0, 1, 64'h11, 0, 0, 8'h00, 3, 0));
        tab.push_back(mk(0, 0,      0, 1, 0, 0,  0, 1, 64'h12, 0, 0, 8'h00, 2, 0));
        tab.push_back(mk(0, 0,      0, 1, 0, 0,  0, 1, 64'h13, 0, 0, 8'h00, 1, 0));
        tab.push_back(mk(0, 0,      0, 1, 0, 0,  0, 1, 64'h14, 0, 0, 8'h00, 0, 0));
        tab.push_back(mk(0, 0,      0, 1, 0, 0,  0, 0, 0,      0, 0, 8'h00, 0, 0));
        // protocol errors 03 and 04; clear racing a new error
        tab.push_back(mk(1, 64'h20, 0, 1, 0, 0,  1, 0, 0,      0, 0, 8'h00, 1, 0));
        tab.push_back(mk(0, 0,      1, 1, 0, 0,  0, 1, 64'h20, 0, 0, 8'h00, 0, 0));
        tab.push_back(mk(1, 64'h21, 0, 0, 0, 0,  0, 1, 64'h20, 0, 1, 8'h03, 0, 1));
        tab.push_back(mk(0, 0,      0, 1, 0, 1,  0, 0, 0,      0, 0, 8'h00, 0, 0));
        tab.push_back(mk(0, 0,      1, 1, 0, 0,  0, 0, 0,      0, 0, 8'h00, 0, 0));
        tab.push_back(mk(0, 0,      1, 1, 0, 0,  0, 0, 0,      0, 1, 8'h04, 0, 1));
        tab.push_back(mk(1, 64'h22, 0, 1, 1, 1,  0, 0, 0,      0, 1, 8'h02, 0, 1));
        tab.push_back(mk(0, 0,      0, 1, 0, 1,  0, 0, 0,      0, 0, 8'h00, 0, 0));

        rst = 1'b1; key_config = 0; in_valid = 0; in_data = '0; flush = 0;
        decomp_rdy = 0; err_clr = 0;
        model_reset();
        repeat (2) @(negedge clk);
        chk("rst_rcvd",  64'(in_rcvd), 0);
        chk("rst_valid", 64'(valid_to_decomp), 0);
        chk("rst_data",  data_to_decomp, 0);
        chk("rst_dump",  64'(dump_decomp), 0);
        chk("rst_error", 64'(error), 0);
        chk("rst_code",  64'(error_code), 0);
        chk("rst_count", 64'(count), 0);
        rst = 1'b0;

        for (int i = 0; i < tab.size(); i++) begin
            drive_cycle(tab[i].iv, tab[i].d, tab[i].fl, tab[i].rdy, tab[i].kc, tab[i].clr);
            chk($sformatf("v%0d_rcvd", i),  64'(in_rcvd),         64'(tab[i].e_rcvd));
            chk($sformatf("v%0d_valid", i), 64'(valid_to_decomp), 64'(tab[i].e_valid));
            if (tab[i].e_valid)
                chk($sformatf("v%0d_data", i), data_to_decomp, tab[i].e_data);
            chk($sformatf("v%0d_dump", i),  64'(dump_decomp),     64'(tab[i].e_dump));
            chk($sformatf("v%0d_error", i), 64'(error),           64'(tab[i].e_err));
            chk($sformatf("v%0d_code", i),  64'(error_code),      64'(tab[i].e_code));
            chk($sformatf("v%0d_count", i), 64'(count),           64'(tab[i].e_count));
            chk($sformatf("v%0d_stall", i), 64'(stall),           64'(tab[i].e_stall));
        end

        // reset mid-stream with count=3 and a word presented
        for (int k = 0; k < 4; k++) drive_cycle(1, 64'h30 + 64'(k), 0, 0, 0, 0);
        chk("mid_count", 64'(count), 3);
        chk("mid_valid", 64'(valid_to_decomp), 1);
        chk("mid_data",  data_to_decomp, 64'h30);
        in_valid = 0;
        #2 rst = 1'b1;
        #1;
        chk("arst_valid", 64'(valid_to_decomp), 0);
        chk("arst_data",  data_to_decomp, 0);
        chk("arst_count", 64'(count), 0);
        chk("arst_rcvd",  64'(in_rcvd), 0);
        chk("arst_error", 64'(error), 0);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        for (int k = 0; k < 3; k++) begin
            drive_cycle(0, 0, 0, 1, 0, 0);
            chk("post_rst_valid", 64'(valid_to_decomp), 0);
            chk("post_rst_count", 64'(count), 0);
        end

        // random traffic against the reference model
        for (int k = 0; k < 3000; k++) begin
            bit iv, fl, rdy, kc, clr;
            logic [63:0] d;
            iv  = ($urandom_range(99) < 45);
            fl  = ($urandom_range(99) < 5);
            rdy = ($urandom_range(99) < 55);
            kc  = ($urandom_range(99) < 6);
            clr = ($urandom_range(99) < 10);
            d   = {$urandom, $urandom};
            drive_cycle(iv, d, fl, rdy, kc, clr);
            cmp_model();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dsec_rx_control.md
Name: dsec_rx_control

Overview:
- Receive-side control for the DSEC link. It consumes the 64-bit words the DSEC transmitter emits as single-cycle out_valid pulses.
- Captures each word into a small FIFO and returns a one-cycle in_rcvd acknowledge to the sender.
- Feeds words to the decompression/decryption path over a valid/ready handshake.
- Sequences end-of-stream flush and dump, and owns the stall/error signalling for the receive path.

Parameters:
- DATA_W, 64, word width of link and decompression input.
- DEPTH, 4, FIFO entries; power of two, at least 2.
- ADDR_W, 2, log2(DEPTH).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous active-high reset
- key_config  input  1  decryption keys being configured; receive path halts
- in_valid  input  1  word present on in_data this cycle; may be a single-cycle pulse
- in_data  input  DATA_W  link data word
- in_rcvd  output  1  registered pulse, one cycle after a word is captured
- flush  input  1  single-cycle end-of-stream request
- decomp_rdy  input  1  decompression unit accepts data_to_decomp this cycle
- data_to_decomp  output  DATA_W  word presented to decompression
- valid_to_decomp  output  1  data_to_decomp valid
- dump_decomp  output  1  tells decompression to emit its residual data
- stall  output  1  combinational: key_config OR error
- error  output  1  sticky error flag
- error_code  output  8  code of the first error since last clear
- err_clr  input  1  clears error and error_code, returns FSM to RUN
- count  output  ADDR_W+1  FIFO occupancy, excluding the output register

Behaviour:
- Reset values: in_rcvd=0, valid_to_decomp=0, data_to_decomp=0, dump_decomp=0, error=0, error_code=8'h00, count=0, FSM=RUN, FIFO pointers 0.
- Reset mid-operation discards all FIFO contents and any pending flush.
- FSM states and transitions:
  - RUN: accept and issue. flush -> DRAIN.
  - DRAIN: issue only; new input is an error. When count==0 and valid_to_decomp==0 -> DUMP.
  - DUMP: dump_decomp=1, held until sampled with decomp_rdy=1; that edge -> RUN and dump_decomp=0.
  - HALT: entered from any state on error detection. Nothing accepted, nothing new issued. err_clr -> RUN, with FIFO contents retained and any pending flush dropped.
- Capture:
  - In RUN, in_valid=1, key_config=0, count<DEPTH: in_data is written at that edge; in_rcvd=1 for exactly the next cycle.
  - Overflow is judged on count at the sampling edge. A same-edge pop does not free a slot.
- Errors: set error and error_code, no capture, no in_rcvd, go to HALT.
  - 8'h01 overflow: in_valid with count==DEPTH.
  - 8'h02: in_valid while key_config=1.
  - 8'h03: in_valid in DRAIN or DUMP.
  - 8'h04: flush while in DRAIN or DUMP.
  - First error wins. A later error before err_clr does not overwrite the code.
  - err_clr and a new error in the same cycle: the new error wins.
- Output stage (registered):
  - Load condition: the output register is empty, or holds a word being accepted this edge (valid_to_decomp & decomp_rdy).
  - When the load condition holds, count>0 and stall=0, the FIFO head loads the output register. Otherwise valid_to_decomp drops after acceptance.
  - Latency: in_valid at edge N into an empty path gives valid_to_decomp=1 from edge N+1.
  - Once asserted, valid_to_decomp and data_to_decomp are held stable until accepted, even if stall rises. Stall only blocks new loads.
- Ordering: words are delivered to decompression in capture order.
- count: updates on every write and pop. Simultaneous write and pop leaves count unchanged. Pointers wrap modulo DEPTH.
- key_config in DRAIN or DUMP freezes progress (no new loads; dump_decomp stays asserted) without an error, unless in_valid also arrives.

Test Plan:
- Single word: after reset, in_valid pulse with 64'hDEADBEEF_01234567, decomp_rdy=1 -> in_rcvd=1 next cycle; valid_to_decomp=1 with that data one cycle after capture, for one cycle; count returns to 0.
- Backpressure fill: decomp_rdy=0, 5 words 1..5 -> word 1 is held in the output register, count=4. Sixth word -> error=1, error_code=8'h01, no in_rcvd. Then err_clr and decomp_rdy=1 -> words 1..5 delivered in order.
- Flush sequence: 3 words then flush with decomp_rdy=1 -> all 3 delivered, then dump_decomp=1 until decomp_rdy is sampled; FSM back in RUN; a further in_valid is accepted normally.
- Key config: key_config=1 with a word in the output register and decomp_rdy=0 -> stall=1, word held stable. in_valid during key_config -> error_code=8'h02; a later overflow leaves the code at 8'h02.
- Protocol errors: in_valid during DRAIN -> error_code=8'h03. After err_clr, flush, flush -> error_code=8'h04.
- Reset mid-stream: assert rst with count=3 and valid_to_decomp=1 -> all outputs return to reset values asynchronously, and no stale word is presented after release.
